core: RTL and testbench

Single-issue, multi-cycle RV32 integer execution core for the FPGA processor. It accepts one 32-bit instruction per handshake and decodes it. It reads a 32×32 register file, executes on an internal ALU, and writes the result back. Alongside execution it maintains performance counters: instruction, ALU-op and register-access totals, most-used register and ALU op, and an estimated-power figure. Instructions come from an external fetch/test source; there is no memory interface.

---
 rtl/core_pkg.sv | 75 +++++++
 rtl/core_alu.sv | 28 ++
 rtl/core.sv | 205 ++++++++++++++++++++
 tb/tb_core.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared encodings, ALU op codes, FSM states and power weights for core
package core_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam int NUM_ALU_OPS = 10;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK
  } state_e;

  typedef enum logic [1:0] {
    K_NONE,
    K_RTYPE,
    K_ITYPE
  } kind_e;

  localparam logic [7:0] PWR_ADDSUB = 8'd20;
  localparam logic [7:0] PWR_LOGIC  = 8'd10;
  localparam logic [7:0] PWR_CMP    = 8'd15;
  localparam logic [7:0] PWR_SHIFT  = 8'd25;
  localparam logic [7:0] PWR_UNSUP  = 8'd5;

  // Base weight of the op plus half the set bits of its result, clamped to 8 bits.
  function automatic logic [7:0] power_of(input logic supported, input alu_op_e op,
                                          input logic [31:0] res);
    logic [5:0] pc;
    logic [7:0] base;
    logic [8:0] sum;
    pc = 6'd0;
    for (int i = 0; i < 32; i++) pc = pc + 6'(res[i]);
    if (!supported) begin
      base = PWR_UNSUP;
    end else begin
      case (op)
        ALU_ADD, ALU_SUB:         base = PWR_ADDSUB;
        ALU_AND, ALU_OR, ALU_XOR: base = PWR_LOGIC;
        ALU_SLT, ALU_SLTU:        base = PWR_CMP;
        default:                  base = PWR_SHIFT;
      endcase
    end
    sum = {1'b0, base} + {4'b0, pc[5:1]};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/core_alu.sv
// rtl/core_alu.sv - combinational RV32 integer ALU for the ten supported op codes
module core_alu
  import core_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  always_comb begin
    result = 32'd0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLT:  result = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'd0, a < b};
      ALU_SLL:  result = a << b[4:0];
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
      default:  result = 32'd0;
    endcase
  end

endmodule

// File: rtl/core.sv
// rtl/core.sv - multi-cycle RV32 execution core with register file and performance monitor
module core
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        validInstruction,
  output logic        completeInstruction,
  output logic [31:0] totalInstructions,
  output logic [31:0] totalOperationsALU,
  output logic [31:0] totalRegAccesses,
  output logic [7:0]  currentEstimatedPower,
  output logic [4:0]  mostUsedReg,
  output logic [3:0]  mostUsedOpsALU,
  output logic [4:0]  rs1Debug,
  output logic [4:0]  rs2Debug,
  output logic [4:0]  rdDebug,
  output logic [31:0] rsData1Debug,
  output logic [31:0] rsData2Debug,
  output logic [31:0] resultALUDebug
);

  state_e      state_q, state_d;
  logic [31:0] instr_q;
  logic [31:0] regs_q [32];

  kind_e       kind_q;
  alu_op_e     op_q;
  logic [4:0]  rs1_q, rs2_q, rd_q;
  logic [31:0] rs1_data_q, op_b_q, result_q;
  logic        complete_q;
  logic [31:0] total_instr_q, total_ops_q, reg_acc_q;
  logic [7:0]  power_q;

  logic [15:0] reg_cnt_q [32];
  logic [15:0] op_cnt_q [NUM_ALU_OPS];
  logic [4:0]  reg_lead_q, reg_lead_d;
  logic [3:0]  op_lead_q, op_lead_d;

  logic [6:0]  dec_opcode, dec_f7;
  logic [2:0]  dec_f3;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [31:0] dec_imm;
  kind_e       dec_kind;
  alu_op_e     dec_op;
  logic [31:0] alu_result;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (validInstruction) state_d = S_DECODE;
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE:   state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  assign dec_opcode = instr_q[6:0];
  assign dec_rd     = instr_q[11:7];
  assign dec_f3     = instr_q[14:12];
  assign dec_rs1    = instr_q[19:15];
  assign dec_rs2    = instr_q[24:20];
  assign dec_f7     = instr_q[31:25];
  assign dec_imm    = {{20{instr_q[31]}}, instr_q[31:20]};

  // Anything not matched here stays K_NONE and retires as a no-op.
  always_comb begin
    dec_kind = K_NONE;
    dec_op   = ALU_ADD;
    if (dec_opcode == OPC_OP) begin
      case (dec_f3)
        F3_ADD_SUB: begin
          if (dec_f7 == F7_BASE)     begin dec_kind = K_RTYPE; dec_op = ALU_ADD; end
          else if (dec_f7 == F7_ALT) begin dec_kind = K_RTYPE; dec_op = ALU_SUB; end
        end
        F3_AND:  begin dec_kind = K_RTYPE; dec_op = ALU_AND;  end
        F3_OR:   begin dec_kind = K_RTYPE; dec_op = ALU_OR;   end
        F3_XOR:  begin dec_kind = K_RTYPE; dec_op = ALU_XOR;  end
        F3_SLT:  begin dec_kind = K_RTYPE; dec_op = ALU_SLT;  end
        F3_SLTU: begin dec_kind = K_RTYPE; dec_op = ALU_SLTU; end
        F3_SLL:  begin dec_kind = K_RTYPE; dec_op = ALU_SLL;  end
        F3_SRL_SRA: begin
          if (dec_f7 == F7_BASE)     begin dec_kind = K_RTYPE; dec_op = ALU_SRL; end
          else if (dec_f7 == F7_ALT) begin dec_kind = K_RTYPE; dec_op = ALU_SRA; end
        end
        default: ;
      endcase
    end else if (dec_opcode == OPC_OP_IMM && dec_f3 == F3_ADD_SUB) begin
      dec_kind = K_ITYPE;
      dec_op   = ALU_ADD;
    end
  end

  core_alu u_alu (
    .op     (op_q),
    .a      (rs1_data_q),
    .b      (op_b_q),
    .result (alu_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q       <= 32'd0;
      kind_q        <= K_NONE;
      op_q          <= ALU_ADD;
      rs1_q         <= 5'd0;
      rs2_q         <= 5'd0;
      rd_q          <= 5'd0;
      rs1_data_q    <= 32'd0;
      op_b_q        <= 32'd0;
      result_q      <= 32'd0;
      complete_q    <= 1'b0;
      total_instr_q <= 32'd0;
      total_ops_q   <= 32'd0;
      reg_acc_q     <= 32'd0;
      power_q       <= 8'd0;
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: if (validInstruction) instr_q <= instruction;
        S_DECODE: begin
          kind_q     <= dec_kind;
          op_q       <= dec_op;
          rs1_q      <= dec_rs1;
          rs2_q      <= dec_rs2;
          rd_q       <= dec_rd;
          rs1_data_q <= regs_q[dec_rs1];
          op_b_q     <= (dec_kind == K_ITYPE) ? dec_imm : regs_q[dec_rs2];
        end
        S_EXECUTE: result_q <= (kind_q == K_NONE) ? 32'd0 : alu_result;
        S_WRITEBACK: begin
          total_instr_q <= total_instr_q + 32'd1;
          power_q       <= power_of(kind_q != K_NONE, op_q, result_q);
          if (kind_q != K_NONE) begin
            if (rd_q != 5'd0) regs_q[rd_q] <= result_q;
            total_ops_q <= total_ops_q + 32'd1;
            reg_acc_q   <= reg_acc_q + ((kind_q == K_RTYPE) ? 32'd3 : 32'd2);
          end
        end
        default: ;
      endcase
      // Completion is registered, so it is visible in the cycle after WRITEBACK.
      complete_q <= (state_q == S_WRITEBACK);
    end
  end

  logic        use_en, op_en;
  logic [4:0]  use_idx;
  logic [15:0] reg_cnt_d, op_cnt_d;

  always_comb begin
    use_en  = 1'b0;
    use_idx = dec_rs1;
    case (state_q)
      S_DECODE:    begin use_en = (dec_kind != K_NONE); use_idx = dec_rs1; end
      S_EXECUTE:   begin use_en = (kind_q == K_RTYPE);  use_idx = rs2_q;   end
      S_WRITEBACK: begin use_en = (kind_q != K_NONE);   use_idx = rd_q;    end
      default: ;
    endcase
    reg_cnt_d  = (reg_cnt_q[use_idx] == 16'hFFFF) ? 16'hFFFF : reg_cnt_q[use_idx] + 16'd1;
    reg_lead_d = reg_lead_q;
    if (use_en && reg_cnt_d > reg_cnt_q[reg_lead_q]) reg_lead_d = use_idx;

    op_en     = (state_q == S_WRITEBACK) && (kind_q != K_NONE);
    op_cnt_d  = (op_cnt_q[op_q] == 16'hFFFF) ? 16'hFFFF : op_cnt_q[op_q] + 16'd1;
    op_lead_d = op_lead_q;
    if (op_en && op_cnt_d > op_cnt_q[op_lead_q]) op_lead_d = op_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_lead_q <= 5'd0;
      op_lead_q  <= 4'd0;
      for (int i = 0; i < 32; i++) reg_cnt_q[i] <= 16'd0;
      for (int i = 0; i < NUM_ALU_OPS; i++) op_cnt_q[i] <= 16'd0;
    end else begin
      reg_lead_q <= reg_lead_d;
      op_lead_q  <= op_lead_d;
      if (use_en) reg_cnt_q[use_idx] <= reg_cnt_d;
      if (op_en)  op_cnt_q[op_q]     <= op_cnt_d;
    end
  end

  assign completeInstruction   = complete_q;
  assign totalInstructions     = total_instr_q;
  assign totalOperationsALU    = total_ops_q;
  assign totalRegAccesses      = reg_acc_q;
  assign currentEstimatedPower = power_q;
  assign mostUsedReg           = reg_lead_q;
  assign mostUsedOpsALU        = op_lead_q;
  assign rs1Debug              = rs1_q;
  assign rs2Debug              = rs2_q;
  assign rdDebug               = rd_q;
  assign rsData1Debug          = rs1_data_q;
  assign rsData2Debug          = op_b_q;
  assign resultALUDebug        = result_q;

endmodule

// File: tb/tb_core.sv
// tb/tb_core.sv - directed self-checking bench for core
module tb_core;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        validInstruction;
  logic        completeInstruction;
  logic [31:0] totalInstructions, totalOperationsALU, totalRegAccesses;
  logic [7:0]  currentEstimatedPower;
  logic [4:0]  mostUsedReg, rs1Debug, rs2Debug, rdDebug;
  logic [3:0]  mostUsedOpsALU;
  logic [31:0] rsData1Debug, rsData2Debug, resultALUDebug;

  int checks = 0;
  int errors = 0;
  int lat;
  int pulses;

  core dut (
    .clk                   (clk),
    .reset                 (reset),
    .instruction           (instruction),
    .validInstruction      (validInstruction),
    .completeInstruction   (completeInstruction),
    .totalInstructions     (totalInstructions),
    .totalOperationsALU    (totalOperationsALU),
    .totalRegAccesses      (totalRegAccesses),
    .currentEstimatedPower (currentEstimatedPower),
    .mostUsedReg           (mostUsedReg),
    .mostUsedOpsALU        (mostUsedOpsALU),
    .rs1Debug              (rs1Debug),
    .rs2Debug              (rs2Debug),
    .rdDebug               (rdDebug),
    .rsData1Debug          (rsData1Debug),
    .rsData2Debug          (rsData2Debug),
    .resultALUDebug        (resultALUDebug)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  // Issue one instruction; return negedges from valid drop to completion (0 = never).
  task automatic issue(input logic [31:0] ins, output int l);
    @(negedge clk);
    instruction = ins;
    validInstruction = 1'b1;
    @(negedge clk);
    validInstruction = 1'b0;
    l = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (completeInstruction) begin
        l = k;
        break;
      end
    end
  endtask

  task automatic run(input string tag, input logic [31:0] ins);
    issue(ins, lat);
    chk({tag, " latency"}, lat, 32'd3);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    validInstruction = 1'b0;
    instruction = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst complete", completeInstruction, 32'd0);
    chk("rst totalInstr", totalInstructions, 32'd0);
    chk("rst totalOps", totalOperationsALU, 32'd0);
    chk("rst regAcc", totalRegAccesses, 32'd0);
    chk("rst power", currentEstimatedPower, 32'd0);
    chk("rst mostReg", mostUsedReg, 32'd0);
    chk("rst mostOp", mostUsedOpsALU, 32'd0);
    chk("rst result", resultALUDebug, 32'd0);

    run("add0", 32'h000000B3);
    chk("add0 rd", rdDebug, 32'd1);
    chk("add0 result", resultALUDebug, 32'd0);
    chk("add0 totalInstr", totalInstructions, 32'd1);
    chk("add0 regAcc", totalRegAccesses, 32'd3);
    chk("add0 power", currentEstimatedPower, 32'd20);
    @(negedge clk);
    chk("add0 pulse width", completeInstruction, 32'd0);

    run("addi5", addi(5'd1, 5'd0, 12'd5));
    chk("addi5 result", resultALUDebug, 32'd5);
    chk("addi5 power", currentEstimatedPower, 32'd21);
    run("addim3", addi(5'd2, 5'd0, 12'hFFD));
    chk("addim3 result", resultALUDebug, 32'hFFFFFFFD);
    chk("addim3 power", currentEstimatedPower, 32'd35);
    run("sub", rtype(7'h20, 3'b000, 5'd3, 5'd1, 5'd2));
    chk("sub result", resultALUDebug, 32'd8);
    chk("sub rs1", rs1Debug, 32'd1);
    chk("sub rs2", rs2Debug, 32'd2);
    chk("sub rd", rdDebug, 32'd3);
    chk("sub data1", rsData1Debug, 32'd5);
    chk("sub data2", rsData2Debug, 32'hFFFFFFFD);
    run("slt", rtype(7'h00, 3'b010, 5'd4, 5'd2, 5'd1));
    chk("slt result", resultALUDebug, 32'd1);
    run("sltu", rtype(7'h00, 3'b011, 5'd5, 5'd2, 5'd1));
    chk("sltu result", resultALUDebug, 32'd0);
    run("and", rtype(7'h00, 3'b111, 5'd6, 5'd1, 5'd2));
    chk("and result", resultALUDebug, 32'd5);
    run("or", rtype(7'h00, 3'b110, 5'd7, 5'd1, 5'd2));
    chk("or result", resultALUDebug, 32'hFFFFFFFD);
    run("xor", rtype(7'h00, 3'b100, 5'd8, 5'd1, 5'd2));
    chk("xor result", resultALUDebug, 32'hFFFFFFF8);
    run("sll", rtype(7'h00, 3'b001, 5'd9, 5'd1, 5'd4));
    chk("sll result", resultALUDebug, 32'h0000000A);
    run("srl", rtype(7'h00, 3'b101, 5'd10, 5'd1, 5'd4));
    chk("srl result", resultALUDebug, 32'd2);
    run("sra", rtype(7'h20, 3'b101, 5'd11, 5'd1, 5'd4));
    chk("sra result", resultALUDebug, 32'd2);
    run("sra neg", rtype(7'h20, 3'b101, 5'd12, 5'd2, 5'd4));
    chk("sra neg result", resultALUDebug, 32'hFFFFFFFE);
    run("srl neg", rtype(7'h00, 3'b101, 5'd13, 5'd2, 5'd4));
    chk("srl neg result", resultALUDebug, 32'h7FFFFFFE);
    chk("srl neg power", currentEstimatedPower, 32'd40);
    chk("phaseA totalInstr", totalInstructions, 32'd14);
    chk("phaseA totalOps", totalOperationsALU, 32'd14);
    chk("phaseA regAcc", totalRegAccesses, 32'd40);
    chk("phaseA mostReg", mostUsedReg, 32'd1);
    chk("phaseA mostOp", mostUsedOpsALU, 32'd0);

    do_reset();
    run("addi x0", addi(5'd0, 5'd0, 12'd7));
    chk("addi x0 result", resultALUDebug, 32'd7);
    run("read x0", 32'h000000B3);
    chk("read x0 result", resultALUDebug, 32'd0);
    run("unsup", 32'h0000007F);
    chk("unsup result", resultALUDebug, 32'd0);
    chk("unsup totalInstr", totalInstructions, 32'd3);
    chk("unsup totalOps", totalOperationsALU, 32'd2);
    chk("unsup regAcc", totalRegAccesses, 32'd5);
    chk("unsup power", currentEstimatedPower, 32'd5);

    do_reset();
    for (int i = 0; i < 5; i++) run("rep add", 32'h000000B3);
    for (int i = 0; i < 3; i++) run("rep sub", rtype(7'h20, 3'b000, 5'd2, 5'd0, 5'd0));
    chk("rep totalInstr", totalInstructions, 32'd8);
    chk("rep totalOps", totalOperationsALU, 32'd8);
    chk("rep regAcc", totalRegAccesses, 32'd24);
    chk("rep mostReg", mostUsedReg, 32'd0);
    chk("rep mostOp", mostUsedOpsALU, 32'd0);

    do_reset();
    run("lead sub", rtype(7'h20, 3'b000, 5'd5, 5'd6, 5'd6));
    chk("lead sub mostReg", mostUsedReg, 32'd6);
    chk("lead sub mostOp", mostUsedOpsALU, 32'd1);
    run("lead add", rtype(7'h00, 3'b000, 5'd7, 5'd7, 5'd7));
    chk("lead add mostReg", mostUsedReg, 32'd7);
    chk("lead add mostOp tie", mostUsedOpsALU, 32'd1);
    run("addi100", addi(5'd10, 5'd0, 12'd100));
    chk("addi100 result", resultALUDebug, 32'd100);
    chk("addi100 mostOp", mostUsedOpsALU, 32'd0);

    @(negedge clk);
    instruction = addi(5'd3, 5'd0, 12'd9);
    validInstruction = 1'b1;
    @(negedge clk);
    validInstruction = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst complete", completeInstruction, 32'd0);
    chk("midrst totalInstr", totalInstructions, 32'd0);
    chk("midrst totalOps", totalOperationsALU, 32'd0);
    chk("midrst regAcc", totalRegAccesses, 32'd0);
    chk("midrst power", currentEstimatedPower, 32'd0);
    chk("midrst mostReg", mostUsedReg, 32'd0);
    chk("midrst mostOp", mostUsedOpsALU, 32'd0);
    chk("midrst rd", rdDebug, 32'd0);
    chk("midrst result", resultALUDebug, 32'd0);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (completeInstruction) pulses++;
    end
    chk("midrst no complete", pulses, 32'd0);
    run("regs cleared", rtype(7'h00, 3'b000, 5'd11, 5'd10, 5'd0));
    chk("regs cleared result", resultALUDebug, 32'd0);
    chk("regs cleared totalInstr", totalInstructions, 32'd1);

    do_reset();
    @(negedge clk);
    instruction = addi(5'd1, 5'd0, 12'd1);
    validInstruction = 1'b1;
    repeat (3) @(negedge clk);
    validInstruction = 1'b0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (completeInstruction) pulses++;
    end
    chk("busy pulses", pulses, 32'd1);
    chk("busy totalInstr", totalInstructions, 32'd1);
    chk("busy regAcc", totalRegAccesses, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
